uart_send: RTL and testbench
============================

# uart_send

UART transmitter for the FIFO-buffered UART subsystem. It is the transmit-side counterpart of `uart_recv`. It pulls bytes from the `uart_sys` output FIFO through that FIFO's Avalon-MM read port (readdata/read/waitrequest) and serialises them onto `tx_wire` as 8N1 (or 8N2) frames, LSB first. Bit timing is derived from the shared oversampling `baud_tick` strobe, the same one `uart_recv` uses, so both directions run at one baud rate.

## Interface
- `OVERSAMPLE`, default 16: `baud_tick` pulses per bit period; legal range 2..256.
- `STOP_BITS`, default 1: stop bits per frame; legal values 1 or 2.
- `clk` in 1: single system clock; all logic on its rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `baud_tick` in 1: one-`clk` strobe at OVERSAMPLE × baud rate.
- `data_out` in 8: FIFO readdata; valid on the cycle a read completes.
- `data_out_wait` in 1: FIFO waitrequest; high = read not accepted this cycle (FIFO empty).
- `data_out_read` out 1: FIFO read request.
- `tx_wire` out 1: serial output; idles high.
- `tx_busy` out 1: high while a frame is being shifted out.

## Operation
- Reset values, applied on the cycle after `rst` is sampled high:
  - `tx_wire` = 1
  - `tx_busy` = 0
  - `data_out_read` = 0
  - state = IDLE
  - tick counter = 0, bit counter = 0
- `data_out_read` is also forced to 0 combinationally while `rst` = 1.
- States: IDLE → START → DATA → STOP → IDLE.
- IDLE:
  - `data_out_read` = 1 and `tx_wire` = 1.
  - A read completes on any cycle with `data_out_read` = 1 and `data_out_wait` = 0. On that cycle `data_out` is captured into the shift register and the next state is START.
  - While `data_out_wait` = 1, stay in IDLE with read held high; no byte is consumed.
- START: `tx_wire` = 0 for one bit period.
- DATA:
  - `tx_wire` = shift register bit 0.
  - Shift right once per completed bit period.
  - 8 bits total, tracked by a 3-bit counter 0..7. Leave DATA when the counter is 7 and the bit period ends.
- STOP: `tx_wire` = 1 for STOP_BITS bit periods, then IDLE.
- Bit period:
  - The tick counter (width clog2(OVERSAMPLE)) is cleared on every state entry and increments only on `baud_tick`.
  - The period ends on the `baud_tick` that takes the counter from OVERSAMPLE−1 back to 0.
  - `clk` cycles without `baud_tick` hold all state.
- `data_out_read` is 0 in START/DATA/STOP. Exactly one FIFO read is issued per frame, and a read is never issued while a byte is pending.
- `tx_busy` = 1 in START, DATA and STOP; 0 in IDLE.
- Reset mid-frame: the frame is abandoned and `tx_wire` returns high on the next cycle. The consumed byte is lost and is not re-read.

## Timing
- Read-to-line latency: `tx_wire` falls on the cycle after the completing read (registered output).
- Frame length is exactly (1 + 8 + STOP_BITS) × OVERSAMPLE `baud_tick` pulses, independent of `clk`/`baud_tick` ratio.
- All level changes on `tx_wire` occur on the cycle after the period-ending `baud_tick`.
- Back-to-back frames:
  - On the cycle after the last stop period ends, the state is IDLE with `data_out_read` = 1.
  - If the FIFO is non-empty, the next start bit begins 2 `clk` cycles after the stop period ended.
  - No extra `baud_tick` idle period is inserted.
- `baud_tick` coinciding with a completing read is not counted toward the start bit. The counter is cleared on START entry, so the start bit lasts exactly OVERSAMPLE ticks counted after entry.
- `baud_tick` coinciding with `rst` = 1 is ignored.
- The FIFO is never read twice per frame; `data_out` is ignored outside a completing read.

## Test plan
- Single byte 0xA5, OVERSAMPLE=16, STOP_BITS=1, `baud_tick` every 4 clk:
  - `tx_wire` sequence 0,1,0,1,0,0,1,0,1,1.
  - Each level lasts 16 ticks (64 clk); 160 ticks total.
  - One read pulse; `tx_busy` high 160 ticks, then low.
- Empty FIFO (`data_out_wait`=1) for 1000 cycles → `data_out_read` held 1, `tx_wire`=1, `tx_busy`=0, no state change.
- Then lower `data_out_wait` with 0x00 → frame 0, then eight 0s, then 1.
- FIFO preloaded 0x55, 0xFF, 0x01:
  - Three contiguous frames.
  - Exactly 3 completed reads.
  - Start bit of each follow-on frame begins 2 clk after the previous stop period ends.
  - Decoded bytes match in order.
- STOP_BITS=2, OVERSAMPLE=8, byte 0x80 → frame lasts 88 ticks; bit 7 high for 8 ticks, followed by 16 ticks high.
- Assert `rst` for 1 cycle during data bit 3 of 0xC3:
  - Next cycle: `tx_wire`=1, `tx_busy`=0, `data_out_read`=0.
  - After release, the next FIFO byte is read and transmitted as a complete frame; 0xC3 is not retransmitted.
- Loopback into `uart_recv` at OVERSAMPLE=16, 256 random bytes → received sequence identical, no framing errors.

Source files
------------

// File: rtl/uart_send.sv
// uart_send: 8N1/8N2 UART transmitter fed from an Avalon-MM FIFO read port.
// Each bit lasts OVERSAMPLE baud_tick strobes; frames go out LSB first on tx_wire.
module uart_send #(
   parameter int unsigned OVERSAMPLE = 16,
   parameter int unsigned STOP_BITS  = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       baud_tick,
   input  logic [7:0] data_out,
   input  logic       data_out_wait,
   output logic       data_out_read,
   output logic       tx_wire,
   output logic       tx_busy
);

   localparam int unsigned      TickW    = $clog2(OVERSAMPLE);
   localparam logic [TickW-1:0] TickLast = TickW'(OVERSAMPLE - 1);
   localparam logic [2:0]       StopLast = 3'(STOP_BITS - 1);

   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

   state_e           state_q, state_d;
   logic [TickW-1:0] tick_q, tick_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       shift_q, shift_d;
   logic             tx_q, tx_d;
   logic             period_end;

   assign period_end    = baud_tick && (tick_q == TickLast);
   assign data_out_read = (state_q == StIdle) && !rst;
   assign tx_busy       = (state_q != StIdle);
   assign tx_wire       = tx_q;

   always_comb begin
      state_d = state_q;
      tick_d  = tick_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      tx_d    = 1'b1;

      if (baud_tick && (state_q != StIdle)) begin
         tick_d = period_end ? '0 : tick_q + 1'b1;
      end

      unique case (state_q)
         StIdle: begin
            if (!data_out_wait) begin
               shift_d = data_out;
               state_d = StStart;
            end
         end
         StStart: begin
            if (period_end) state_d = StData;
         end
         StData: begin
            if (period_end) begin
               shift_d = {1'b0, shift_q[7:1]};
               if (bit_q == 3'd7) state_d = StStop;
               else               bit_d   = bit_q + 3'd1;
            end
         end
         StStop: begin
            // bit_q is reused to count stop periods
            if (period_end) begin
               if (bit_q == StopLast) state_d = StIdle;
               else                   bit_d   = bit_q + 3'd1;
            end
         end
         default: state_d = StIdle;
      endcase

      // Every state entry starts a fresh bit period
      if (state_d != state_q) begin
         tick_d = '0;
         bit_d  = '0;
      end

      // Line level is registered from the next state so it changes with the state
      unique case (state_d)
         StStart: tx_d = 1'b0;
         StData:  tx_d = shift_d[0];
         default: tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         tick_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         tick_q  <= tick_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
      end
   end

endmodule

// File: tb/tb_uart_send.sv
// tb_uart_send: scoreboard bench for uart_send; a FIFO model feeds bytes and a
// tick-counting line decoder checks each frame against the queued expectation.
module tb_uart_send;

   localparam int unsigned Os0 = 16;
   localparam int unsigned Os1 = 8;

   logic       clk;
   logic       rst;
   logic       baud_tick;
   logic [7:0] d0, d1;
   logic       w0, w1, r0, r1;
   logic       tx0, tx1, busy0, busy1;

   logic [7:0] fifo0[$];
   logic [7:0] fifo1[$];
   logic [7:0] exp0[$];
   int         tick_div  = 4;
   int         reads0    = 0;
   int         reads1    = 0;
   int         n_tests   = 0;
   int         n_fail    = 0;
   bit         dut1_done = 1'b0;

   uart_send #(.OVERSAMPLE(Os0), .STOP_BITS(1)) u_dut0 (
      .clk           (clk),
      .rst           (rst),
      .baud_tick     (baud_tick),
      .data_out      (d0),
      .data_out_wait (w0),
      .data_out_read (r0),
      .tx_wire       (tx0),
      .tx_busy       (busy0)
   );

   uart_send #(.OVERSAMPLE(Os1), .STOP_BITS(2)) u_dut1 (
      .clk           (clk),
      .rst           (rst),
      .baud_tick     (baud_tick),
      .data_out      (d1),
      .data_out_wait (w1),
      .data_out_read (r1),
      .tx_wire       (tx1),
      .tx_busy       (busy1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input int act, input int want);
      n_tests++;
      if (act != want) begin
         n_fail++;
         $display("FAIL %s: got %0d, want %0d", name, act, want);
      end
   endtask

   task automatic timeout(input string name, input int n);
      n_tests++;
      n_fail++;
      $display("FAIL %s: no response within %0d cycles", name, n);
   endtask

   // Inputs change on the falling edge; a read completes at the next rising edge.
   initial begin : drive
      int div_cnt;
      div_cnt   = 0;
      baud_tick = 1'b0;
      d0 = 8'h00; w0 = 1'b1;
      d1 = 8'h00; w1 = 1'b1;
      forever begin
         @(negedge clk);
         div_cnt++;
         if (div_cnt >= tick_div) begin
            baud_tick = 1'b1;
            div_cnt   = 0;
         end else begin
            baud_tick = 1'b0;
         end
         w0 = (fifo0.size() == 0);
         d0 = (fifo0.size() != 0) ? fifo0[0] : 8'h00;
         w1 = (fifo1.size() == 0);
         d1 = (fifo1.size() != 0) ? fifo1[0] : 8'h00;
         #1;
         if (r0 === 1'b1 && w0 === 1'b0) begin
            void'(fifo0.pop_front());
            reads0++;
         end
         if (r1 === 1'b1 && w1 === 1'b0) begin
            void'(fifo1.pop_front());
            reads1++;
         end
      end
   end

   // Frame decoder for dut0: counts consumed ticks, samples each bit period.
   initial begin : monitor
      bit         in_frame, expect_start, first, busy_bad;
      int         bit_idx, cnt, glitches;
      logic       lvl;
      logic [7:0] got, want;
      in_frame = 1'b0; expect_start = 1'b0; first = 1'b0; busy_bad = 1'b0;
      bit_idx = 0; cnt = 0; glitches = 0; lvl = 1'b1; got = '0; want = '0;
      forever begin
         @(posedge clk);
         #2;
         if (rst === 1'b1) begin
            in_frame     = 1'b0;
            expect_start = 1'b0;
         end else if (!in_frame) begin
            if (expect_start) begin
               // Line must fall at the edge right after the one ending the stop bit
               chk("b2b_gap", int'(tx0 === 1'b0), 1);
               expect_start = 1'b0;
            end
            if (tx0 === 1'b0) begin
               in_frame = 1'b1;
               bit_idx  = 0;
               cnt      = 0;
               glitches = 0;
               busy_bad = (busy0 !== 1'b1);
               lvl      = 1'b0;
               first    = 1'b0;
               got      = '0;
            end
         end else begin
            if (baud_tick === 1'b1) begin
               cnt++;
               if (cnt == Os0) begin
                  cnt = 0;
                  bit_idx++;
                  first = 1'b1;
               end
            end
            if (bit_idx == 10) begin
               in_frame = 1'b0;
               chk("busy_after_frame", int'(busy0), 0);
               chk("line_glitch", glitches, 0);
               chk("busy_in_frame", int'(busy_bad), 0);
               chk("stop_level", int'(lvl), 1);
               if (exp0.size() == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL frame_unexpected: got 0x%02h, nothing queued", got);
               end else begin
                  want = exp0.pop_front();
                  chk("frame_byte", int'(got), int'(want));
               end
               expect_start = (fifo0.size() != 0);
            end else begin
               if (busy0 !== 1'b1) busy_bad = 1'b1;
               if (first) begin
                  first = 1'b0;
                  lvl   = tx0;
                  if (bit_idx >= 1 && bit_idx <= 8) got[bit_idx-1] = tx0;
               end else if (tx0 !== lvl) begin
                  glitches++;
               end
            end
         end
      end
   end

   task automatic wait_busy(input string name, input int budget);
      int n = 0;
      while (busy0 !== 1'b1 && n < budget) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (busy0 !== 1'b1) timeout(name, n);
   endtask

   task automatic drain(input string name, input int budget);
      int n = 0;
      while ((exp0.size() != 0 || fifo0.size() != 0 || busy0 === 1'b1) && n < budget) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= budget) timeout(name, n);
   endtask

   // Counts ticks consumed while busy, stopping when busy drops or at the limit.
   task automatic count_ticks(input int limit, input int budget, output int ticks);
      logic pb;
      int   n;
      pb    = busy0;
      ticks = 0;
      n     = 0;
      while (busy0 === 1'b1 && ticks < limit && n < budget) begin
         @(posedge clk);
         #1;
         n++;
         if (pb === 1'b1 && baud_tick === 1'b1) ticks++;
         pb = busy0;
      end
   endtask

   initial begin : main
      int  r0s, ticks, bad;
      byte b;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_tx", int'(tx0), 1);
      chk("rst_busy", int'(busy0), 0);
      chk("rst_read", int'(r0), 0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("idle_read", int'(r0), 1);

      // Single 0xA5 frame, tick every 4 clk
      r0s = reads0;
      fifo0.push_back(8'hA5);
      exp0.push_back(8'hA5);
      wait_busy("a5_start", 100);
      count_ticks(1000, 2000, ticks);
      chk("a5_ticks", ticks, 160);
      chk("a5_busy_end", int'(busy0), 0);
      chk("a5_reads", reads0 - r0s, 1);
      drain("a5_drain", 200);

      // Empty FIFO holds the transmitter idle with read asserted
      r0s = reads0;
      bad = 0;
      repeat (1000) begin
         @(posedge clk);
         #1;
         if (!(r0 === 1'b1 && tx0 === 1'b1 && busy0 === 1'b0)) bad++;
      end
      chk("empty_hold", bad, 0);
      chk("empty_reads", reads0 - r0s, 0);
      fifo0.push_back(8'h00);
      exp0.push_back(8'h00);
      drain("zero_drain", 1000);

      // Three queued bytes go out back to back
      r0s = reads0;
      fifo0.push_back(8'h55); exp0.push_back(8'h55);
      fifo0.push_back(8'hFF); exp0.push_back(8'hFF);
      fifo0.push_back(8'h01); exp0.push_back(8'h01);
      drain("burst_drain", 3000);
      chk("burst_reads", reads0 - r0s, 3);

      // Reset during data bit 3 of 0xC3: that byte is dropped, 0x3C follows
      r0s = reads0;
      fifo0.push_back(8'hC3);
      fifo0.push_back(8'h3C);
      exp0.push_back(8'h3C);
      wait_busy("c3_start", 100);
      count_ticks(72, 1000, ticks);
      chk("c3_ticks_before_rst", ticks, 72);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("midrst_tx", int'(tx0), 1);
      chk("midrst_busy", int'(busy0), 0);
      chk("midrst_read", int'(r0), 0);
      @(negedge clk);
      rst = 1'b0;
      drain("c3_drain", 1500);
      chk("c3_reads", reads0 - r0s, 2);

      // Long stream at one tick per clk
      tick_div = 1;
      r0s = reads0;
      for (int i = 0; i < 256; i++) begin
         b = byte'($urandom_range(0, 255));
         fifo0.push_back(b);
         exp0.push_back(b);
      end
      drain("stream_drain", 60000);
      chk("stream_reads", reads0 - r0s, 256);

      bad = 0;
      while (!dut1_done && bad < 1000) begin
         @(posedge clk);
         bad++;
      end
      if (!dut1_done) timeout("os8_done", bad);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // OVERSAMPLE=8, two stop bits, byte 0x80: 64 ticks low, then 24 high
   initial begin : dut1_chk
      int cnt, low, n, hi_bad;
      @(posedge clk);
      wait (rst === 1'b0);
      @(posedge clk);
      #1;
      fifo1.push_back(8'h80);
      n = 0;
      while (tx1 !== 1'b0 && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (tx1 !== 1'b0) begin
         timeout("os8_start", n);
      end else begin
         cnt = 0; low = -1; n = 0; hi_bad = 0;
         while (busy1 === 1'b1 && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
            if (baud_tick === 1'b1) cnt++;
            if (low >= 0 && tx1 !== 1'b1) hi_bad++;
            if (low < 0 && tx1 === 1'b1) low = cnt;
         end
         chk("os8_low_ticks", low, 64);
         chk("os8_frame_ticks", cnt, 88);
         chk("os8_high_ticks", cnt - low, 24);
         chk("os8_high_steady", hi_bad, 0);
         chk("os8_reads", reads1, 1);
      end
      dut1_done = 1'b1;
   end

endmodule
